irq_controller: RTL and testbench

Memory-mapped interrupt controller on the data bus, beside the Bridge's peripheral decode window. Collects interrupt lines from TC1, TC2 and the external interrupt source. Latches rising edges into a pending register and applies a software mask. Presents one prioritized request at a time to CP0 through a req/ack/EOI handshake, so a new interrupt cannot preempt one still being serviced.

---
 rtl/irq_controller_pkg.sv | 23 ++
 rtl/irq_controller_if.sv | 26 ++
 rtl/irq_prio_pick.sv | 49 ++++
 rtl/irq_controller.sv | 135 +++++++++++++
 tb/tb_irq_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM states, defaults.
package irq_controller_pkg;

    localparam int unsigned N_SRC_DEF     = 3;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_7F30;

    localparam logic [1:0] IRQ_MASK   = 2'd0;
    localparam logic [1:0] IRQ_PEND   = 2'd1;
    localparam logic [1:0] IRQ_ACTIVE = 2'd2;
    localparam logic [1:0] IRQ_EOI    = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Width of a source index; a single source still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Data-bus register port plus interrupt lines and the CP0 req/ack handshake.
interface irq_controller_if
    import irq_controller_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned ID_W  = id_width(N_SRC)
);
    logic [31:0]      addr;
    logic             we;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [N_SRC-1:0] irq_src;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;

    modport master (
        output addr, we, wdata, irq_src, irq_ack,
        input  rdata, irq_req, irq_id
    );

    modport slave (
        input  addr, we, wdata, irq_src, irq_ack,
        output rdata, irq_req, irq_id
    );
endinterface

// File: rtl/irq_prio_pick.sv
// Combinational priority picker over the masked pending vector.
// IRQ_CTRL_RR_EN selects round-robin from last grant + 1; otherwise lowest index wins.
module irq_prio_pick #(
    parameter int unsigned N_SRC = 3,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [ID_W-1:0]  i_last,
    output logic             o_vld_c,
    output logic [ID_W-1:0]  o_idx_c
);

`ifdef IRQ_CTRL_RR_EN
    logic [2*N_SRC-1:0] w_req2;
    logic [N_SRC-1:0]   w_rot;
    int unsigned        w_base;

    // Rotate so position 0 is the source right after the last grant.
    assign w_base = 32'(i_last) + 32'd1;
    assign w_req2 = {i_req, i_req};
    assign w_rot  = N_SRC'(w_req2 >> w_base);

    always_comb begin
        o_vld_c = 1'b0;
        o_idx_c = '0;
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_vld_c = 1'b1;
                o_idx_c = ID_W'((w_base + 32'(k)) % N_SRC);
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    always_comb begin
        o_vld_c = 1'b0;
        o_idx_c = '0;
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_vld_c = 1'b1;
                o_idx_c = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture, mask, one request at a time to CP0.
// Define IRQ_CTRL_RR_EN for round-robin priority (builds the last-grant register).
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned N_SRC     = N_SRC_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input logic            clk,
    input logic            reset,
    irq_controller_if.slave bus
);

    localparam int unsigned ID_W = id_width(N_SRC);

    irq_state_e       r_state;
    logic             r_req;
    logic [ID_W-1:0]  r_id;
    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;

    logic             w_hit;
    logic [1:0]       w_off;
    logic             w_wr_mask;
    logic             w_wr_pend;
    logic             w_wr_eoi;
    logic             w_ack_take;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_masked;
    logic [N_SRC-1:0] w_id_oh;
    logic [N_SRC-1:0] w_clr;
    logic             w_cur_live;
    logic             w_pick_vld;
    logic [ID_W-1:0]  w_pick_idx;
    logic [ID_W-1:0]  w_last;
    logic             w_unused;

    assign w_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = bus.addr[3:2];
    assign w_wr_mask  = w_hit && bus.we && (w_off == IRQ_MASK);
    assign w_wr_pend  = w_hit && bus.we && (w_off == IRQ_PEND);
    assign w_wr_eoi   = w_hit && bus.we && (w_off == IRQ_EOI);
    assign w_ack_take = (r_state == IRQ_REQ) && bus.irq_ack;
    assign w_unused   = ^{bus.addr[1:0], bus.wdata[31:N_SRC]};

    assign w_edge     = bus.irq_src & ~r_src_q;
    assign w_masked   = r_pend & r_mask;
    assign w_id_oh    = N_SRC'(1) << r_id;
    assign w_cur_live = |(w_masked & w_id_oh);
    // Clears from W1C and ack; a same-cycle rising edge still sets the bit.
    assign w_clr      = (w_wr_pend ? bus.wdata[N_SRC-1:0] : '0) | (w_ack_take ? w_id_oh : '0);

    irq_prio_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
        .i_req   (w_masked),
        .i_last  (w_last),
        .o_vld_c (w_pick_vld),
        .o_idx_c (w_pick_idx)
    );

`ifdef IRQ_CTRL_RR_EN
    logic [ID_W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset)           r_last <= ID_W'(N_SRC - 1);
        else if (w_ack_take) r_last <= r_id;
    end
    assign w_last = r_last;
`else
    assign w_last = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
        end else begin
            r_src_q <= bus.irq_src;
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            if (w_wr_mask) r_mask <= bus.wdata[N_SRC-1:0];
        end
    end

    // Request FSM; irq_id only changes when a new request is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IRQ_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= IRQ_REQ;
                        r_req   <= 1'b1;
                        r_id    <= w_pick_idx;
                    end
                end
                IRQ_REQ: begin
                    if (bus.irq_ack) begin
                        r_state <= IRQ_SERVICE;
                        r_req   <= 1'b0;
                    end else if (!w_cur_live) begin
                        r_state <= IRQ_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (w_wr_eoi) r_state <= IRQ_IDLE;
                end
                default: begin
                    r_state <= IRQ_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (w_hit) begin
            case (w_off)
                IRQ_MASK:   bus.rdata = 32'(r_mask);
                IRQ_PEND:   bus.rdata = 32'(r_pend);
                IRQ_ACTIVE: bus.rdata = {(r_state == IRQ_SERVICE), 31'(r_id)};
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq_req = r_req;
    assign bus.irq_id  = r_id;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic against a behavioural model.
module tb_irq_controller;
    import irq_controller_pkg::*;

    localparam int unsigned NS   = 3;
    localparam logic [31:0] BASE = 32'h0000_7F30;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    irq_controller_if #(.N_SRC(NS)) bus();

    irq_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [2:0] m_srcq, m_pend, m_mask;
    logic       m_req, m_svc;
    logic [1:0] m_id;
    int         m_last;

    function automatic int m_pick(input logic [2:0] v);
`ifdef IRQ_CTRL_RR_EN
        for (int k = 0; k < int'(NS); k++) begin
            int idx;
            idx = (m_last + 1 + k) % int'(NS);
            if (v[idx]) return idx;
        end
`else
        for (int k = 0; k < int'(NS); k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if ((a >> 4) != (BASE >> 4)) return 32'h0;
        case (a[3:2])
            2'd0:    return {29'h0, m_mask};
            2'd1:    return {29'h0, m_pend};
            2'd2:    return {m_svc, 29'h0, m_id};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] e, clr;
        logic       hit, nreq, nsvc;
        logic [1:0] nid;
        int         p;
        if (reset) begin
            m_srcq = 0; m_pend = 0; m_mask = 0;
            m_req = 0; m_svc = 0; m_id = 0; m_last = int'(NS) - 1;
            return;
        end
        hit  = ((bus.addr >> 4) == (BASE >> 4));
        e    = bus.irq_src & ~m_srcq;
        clr  = (hit && bus.we && bus.addr[3:2] == 2'd1) ? bus.wdata[2:0] : 3'b000;
        nreq = m_req; nsvc = m_svc; nid = m_id;
        if (m_req) begin
            if (bus.irq_ack) begin
                clr[m_id] = 1'b1;
                nreq = 0; nsvc = 1; m_last = int'(m_id);
            end else if (!(m_pend[m_id] && m_mask[m_id])) begin
                nreq = 0;
            end
        end else if (m_svc) begin
            if (hit && bus.we && bus.addr[3:2] == 2'd3) nsvc = 0;
        end else begin
            p = m_pick(m_pend & m_mask);
            if (p >= 0) begin nreq = 1; nid = 2'(p); end
        end
        m_pend = (m_pend & ~clr) | e;
        if (hit && bus.we && bus.addr[3:2] == 2'd0) m_mask = bus.wdata[2:0];
        m_srcq = bus.irq_src;
        m_req = nreq; m_svc = nsvc; m_id = nid;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        bus.addr  = BASE + 32'(off) * 4;
        bus.we    = 1'b1;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        bus.addr = BASE + 32'(off) * 4;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        bus.we = 0; bus.irq_ack = 0; bus.irq_src = 0; bus.wdata = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.irq_req); end
        checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", bus.irq_id); end
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, d); end
        end
        bus.addr = BASE + 32'h10; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h exp 0", bus.rdata); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h7);
        bus.irq_src = 3'b010;
        tick();
        rd(2'd1, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_pend got %h exp 2", d); end
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got %b exp 0", bus.irq_req); end
        bus.irq_src = 3'b000;
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'd1) begin
            errors++; $display("FAIL basic_req got %b/%0d exp 1/1", bus.irq_req, bus.irq_id); end
        pulse_ack();
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_ack got %h exp 0", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL basic_active got %h exp 80000001", d); end
        wr(2'd3, 32'h0);
        rd(2'd2, d);
        checks++; if (d[31] !== 1'b0 || bus.irq_req !== 1'b0) begin
            errors++; $display("FAIL basic_eoi got active %h req %b exp bit31 0 req 0", d, bus.irq_req); end
    endtask

    task automatic run_order(input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
        logic [1:0] exp_id [3];
        exp_id[0] = e0; exp_id[1] = e1; exp_id[2] = e2;
        bus.irq_src = 3'b111;
        tick();
        bus.irq_src = 3'b000;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== exp_id[k]) begin
                errors++; $display("FAIL order%0d got %b/%0d exp 1/%0d", k, bus.irq_req, bus.irq_id, exp_id[k]); end
            pulse_ack();
            wr(2'd3, 32'h0);
            checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL order_idle%0d got %b exp 0", k, bus.irq_req); end
            tick();
        end
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL order_done got %b exp 0", bus.irq_req); end
    endtask

    task automatic test_priority();
        do_reset();
`ifdef IRQ_CTRL_RR_EN
        wr(2'd0, 32'h2);
        bus.irq_src = 3'b010; tick();
        bus.irq_src = 3'b000; tick();
        checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("FAIL rr_prime got %0d exp 1", bus.irq_id); end
        pulse_ack();
        wr(2'd3, 32'h0);
        wr(2'd0, 32'h7);
        run_order(2'd2, 2'd0, 2'd1);
`else
        wr(2'd0, 32'h7);
        run_order(2'd0, 2'd1, 2'd2);
`endif
    endtask

    task automatic test_mask_drop();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h1);
        bus.irq_src = 3'b001; tick();
        bus.irq_src = 3'b000; tick();
        wr(2'd0, 32'h0);
        checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL mask_hold got %b exp 1", bus.irq_req); end
        tick();
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_drop got %b exp 0", bus.irq_req); end
        rd(2'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_pend got %h exp 1", d); end
        wr(2'd0, 32'h1);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_reidle got %b exp 0", bus.irq_req); end
        tick();
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 2'd0) begin
            errors++; $display("FAIL mask_rereq got %b/%0d exp 1/0", bus.irq_req, bus.irq_id); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        do_reset();
        bus.irq_src = 3'b001; tick();
        bus.irq_src = 3'b000; tick();
        bus.irq_src = 3'b001;
        wr(2'd1, 32'h1);
        rd(2'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL w1c_race got %h exp 1", d); end
        wr(2'd1, 32'h1);
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_level got %h exp 0", d); end
        bus.irq_src = 3'b000;
    endtask

    task automatic test_reset_in_service();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h7);
        bus.irq_src = 3'b001; tick();
        bus.irq_src = 3'b000; tick();
        pulse_ack();
        bus.irq_src = 3'b100; tick();
        bus.irq_src = 3'b000; tick();
        rd(2'd1, d);
        checks++; if (d !== 32'h4 || bus.irq_req !== 1'b0) begin
            errors++; $display("FAIL svc_pend got %h/%b exp 4/0", d, bus.irq_req); end
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(2'(i), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_svc_reg%0d got %h exp 0", i, d); end
        end
        pulse_ack();
        wr(2'd3, 32'h0);
        rd(2'd2, d);
        checks++; if (d !== 32'h0 || bus.irq_req !== 1'b0) begin
            errors++; $display("FAIL rst_svc_ignore got %h/%b exp 0/0", d, bus.irq_req); end
    endtask

    task automatic test_random();
        int unsigned r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) bus.irq_src = 3'($urandom);
            bus.we = 0; bus.irq_ack = 0;
            reset = ($urandom_range(0, 249) == 0);
            r = $urandom_range(0, 9);
            bus.wdata = $urandom;
            if (r == 0)      begin bus.addr = BASE;       bus.we = 1; end
            else if (r == 1) begin bus.addr = BASE + 4;   bus.we = 1; end
            else if (r == 2) begin bus.addr = BASE + 12;  bus.we = 1; end
            else if (r == 3) begin bus.addr = BASE + 32'h20; bus.we = 1; end
            else             bus.addr = BASE + 32'($urandom_range(0, 4)) * 4;
            if (m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0)) bus.irq_ack = 1;
            #1;
            checks++; if (bus.rdata !== m_read(bus.addr)) begin
                errors++; $display("FAIL rand_rdata c%0d addr %h got %h exp %h", c, bus.addr, bus.rdata, m_read(bus.addr)); end
            tick();
            checks++; if (bus.irq_req !== m_req || bus.irq_id !== m_id) begin
                errors++; $display("FAIL rand_req c%0d got %b/%0d exp %b/%0d", c, bus.irq_req, bus.irq_id, m_req, m_id); end
        end
        reset = 0; bus.we = 0; bus.irq_ack = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.addr = 0; bus.we = 0; bus.wdata = 0; bus.irq_src = 0; bus.irq_ack = 0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_drop();
        test_w1c_race();
        test_reset_in_service();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
